// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter with one-entry holding buffer
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int OVS      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic [DBIT_MAX-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [3:0]          data_len,
    input  logic [1:0]          parity_mode,
    input  logic [1:0]          stop_sel,
    output logic                tx,
    output logic                busy,
    output logic                tx_done_tick
);

    localparam int CW = $clog2(2 * OVS);
    localparam int LW = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [CW-1:0] LAST_1  = CW'(OVS - 1);
    localparam logic [CW-1:0] LAST_15 = CW'((OVS * 3) / 2 - 1);
    localparam logic [CW-1:0] LAST_2  = CW'(2 * OVS - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(DBIT_MAX);

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LW-1:0]       bit_q, bit_d;
    logic [LW-1:0]       len_q, len_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d;
    logic                par_en_q, par_en_d;
    logic                par_q, par_d;
    logic [1:0]          stop_q, stop_d;
    logic [DBIT_MAX-1:0] hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                tx_ready_q, tx_ready_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic [LW-1:0]       len_in;
    logic [LW-1:0]       len_eff;
    logic                par_calc;
    logic [CW-1:0]       stop_last;
    logic                load;

    // Frame config seen at load time: clamped length, parity of the used bits, stop length in ticks
    always_comb begin
        len_in  = {1'b0, data_len};
        len_eff = len_in;
        if (len_in == '0 || len_in > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
        par_calc = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (LW'(i) < len_eff) begin
                par_calc = par_calc ^ hold_q[i];
            end
        end
        case (stop_q)
            2'b00:   stop_last = LAST_1;
            2'b01:   stop_last = LAST_15;
            default: stop_last = LAST_2;
        endcase
    end

    // Frame sequencer, holding-buffer handshake and tick counting
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        len_d        = len_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_d        = par_q;
        stop_d       = stop_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (cnt_q == LAST_1) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (cnt_q == LAST_1) begin
                        cnt_d   = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == len_q - LW'(1)) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + LW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (cnt_q == LAST_1) begin
                        cnt_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (cnt_q == stop_last) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading swallows any coincident tick: the new start bit gets a full OVS ticks
        if (load) begin
            state_d      = ST_START;
            cnt_d        = '0;
            bit_d        = '0;
            shift_d      = hold_q;
            len_d        = len_eff;
            par_en_d     = ^parity_mode;
            par_d        = par_calc ^ parity_mode[1];
            stop_d       = stop_sel;
            hold_valid_d = 1'b0;
        end

        // tx_ready low implies the buffer is full, so accept and load never coincide
        if (tx_valid && tx_ready_q) begin
            hold_d       = tx_data;
            hold_valid_d = 1'b1;
        end

        tx_ready_d = ~hold_valid_d;
    end

    // Line level follows the state one clock later so tx is glitch-free from a flop
    always_comb begin
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and drops the buffered word
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_q        <= 1'b0;
            stop_q       <= 2'b00;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_ready_q   <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_ready_q   <= tx_ready_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = tx_ready_q;
    assign busy         = (state_q != ST_IDLE);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [3:0] data_len = 4'd8;
    logic [1:0] parity_mode = 2'b00;
    logic [1:0] stop_sel = 2'b00;
    logic       tx;
    logic       busy;
    logic       tx_done_tick;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int tdiv = 0;
    logic [1:0] samples[$];

    uart_tx_cfg #(.DBIT_MAX(8), .OVS(OVS)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .data_len     (data_len),
        .parity_mode  (parity_mode),
        .stop_sel     (stop_sel),
        .tx           (tx),
        .busy         (busy),
        .tx_done_tick (tx_done_tick)
    );

    initial forever #5 clk = ~clk;

    // Tick every third clock; after each consumed tick record {done, tx}
    initial begin
        forever begin
            @(negedge clk);
            if (s_tick) samples.push_back({tx_done_tick, tx});
            if (tx_done_tick) done_cnt++;
            tdiv = (tdiv == 2) ? 0 : tdiv + 1;
            s_tick = (tdiv == 0);
        end
    end

    task automatic send(input logic [7:0] d);
        int k;
        k = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (k >= 3000) begin
            errors++;
            $display("FAIL send_accept: waited %0d cycles, required < 3000", k);
        end
    endtask

    task automatic wait_done(input int base, input int n);
        int k;
        k = 0;
        while (done_cnt - base < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
    endtask

    // Splits the tick record into bit windows starting at the first low sample
    task automatic decode(input int from, input int nbits, output logic [15:0] bits,
                          output int stop_len, output int gap, output bit clean, output int next);
        int i;
        bit found;
        logic b;
        i = from; bits = '0; gap = 0; clean = 1'b1; found = 1'b0;
        while (i < samples.size() && samples[i][0] == 1'b1) begin
            if (samples[i][1]) clean = 1'b0;
            i++;
            gap++;
        end
        for (int k = 0; k < nbits; k++) begin
            if (i + OVS > samples.size()) begin
                clean = 1'b0;
                break;
            end
            b = samples[i][0];
            bits[k] = b;
            for (int j = 0; j < OVS; j++) begin
                if (samples[i + j] !== {1'b0, b}) clean = 1'b0;
            end
            i += OVS;
        end
        stop_len = 0;
        while (i < samples.size() && !found) begin
            stop_len++;
            if (samples[i][0] !== 1'b1) clean = 1'b0;
            if (samples[i][1]) found = 1'b1;
            i++;
        end
        if (!found) stop_len = -1;
        next = i;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done_tick); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_8n1();
        int base, qb, sl, gp, nx;
        logic [15:0] bits;
        bit cl;
        base = done_cnt; qb = samples.size();
        data_len = 4'd8; parity_mode = 2'b00; stop_sel = 2'b00;
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL 8n1_ready_after_accept: got %b expected 0", tx_ready); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL 8n1_tx_e0: got %b expected 1", tx); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL 8n1_busy_e1: got %b expected 1", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL 8n1_tx_e1: got %b expected 1", tx); end
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL 8n1_tx_e2: got %b expected 0", tx); end
        wait_done(base, 1);
        decode(qb, 9, bits, sl, gp, cl, nx);
        checks++; if (bits[8:0] !== 9'h14A) begin errors++; $display("FAIL 8n1_bits: got %h expected 14a", bits[8:0]); end
        checks++; if (cl !== 1'b1) begin errors++; $display("FAIL 8n1_clean: got %b expected 1", cl); end
        checks++; if (sl != 16) begin errors++; $display("FAIL 8n1_stop_len: got %0d expected 16", sl); end
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL 8n1_done_count: got %0d expected 1", done_cnt - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_7x2(input logic [1:0] pm, input logic [8:0] exp_bits);
        int base, qb, sl, gp, nx;
        logic [15:0] bits;
        bit cl;
        base = done_cnt; qb = samples.size();
        data_len = 4'd7; parity_mode = pm; stop_sel = 2'b10;
        send(8'hC3);
        wait_done(base, 1);
        decode(qb, 9, bits, sl, gp, cl, nx);
        checks++; if (bits[8:0] !== exp_bits) begin errors++; $display("FAIL 7x2_bits pm=%b: got %h expected %h", pm, bits[8:0], exp_bits); end
        checks++; if (cl !== 1'b1) begin errors++; $display("FAIL 7x2_clean pm=%b: got %b expected 1", pm, cl); end
        checks++; if (sl != 32) begin errors++; $display("FAIL 7x2_stop_len pm=%b: got %0d expected 32", pm, sl); end
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL 7x2_done_count pm=%b: got %0d expected 1", pm, done_cnt - base); end
    endtask

    task automatic test_stop_1p5();
        int base, qb, sl, gp, nx;
        logic [15:0] bits;
        bit cl;
        base = done_cnt; qb = samples.size();
        data_len = 4'd8; parity_mode = 2'b00; stop_sel = 2'b01;
        send(8'h3C);
        wait_done(base, 1);
        decode(qb, 9, bits, sl, gp, cl, nx);
        checks++; if (bits[8:0] !== 9'h078) begin errors++; $display("FAIL 1p5_bits: got %h expected 078", bits[8:0]); end
        checks++; if (cl !== 1'b1) begin errors++; $display("FAIL 1p5_clean: got %b expected 1", cl); end
        checks++; if (sl != 24) begin errors++; $display("FAIL 1p5_stop_len: got %0d expected 24", sl); end
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL 1p5_done_count: got %0d expected 1", done_cnt - base); end
    endtask

    task automatic test_back_to_back();
        int base, qb, sl1, sl2, gp1, gp2, nx1, nx2;
        logic [15:0] b1, b2;
        bit cl1, cl2;
        logic busy_at_second;
        base = done_cnt; qb = samples.size();
        data_len = 4'd8; parity_mode = 2'b00; stop_sel = 2'b00;
        send(8'h01);
        send(8'h80);
        busy_at_second = busy;
        wait_done(base, 2);
        decode(qb, 9, b1, sl1, gp1, cl1, nx1);
        decode(nx1, 9, b2, sl2, gp2, cl2, nx2);
        checks++; if (busy_at_second !== 1'b1) begin errors++; $display("FAIL b2b_accept_during_frame: busy %b expected 1", busy_at_second); end
        checks++; if (b1[8:0] !== 9'h002) begin errors++; $display("FAIL b2b_bits1: got %h expected 002", b1[8:0]); end
        checks++; if (sl1 != 16) begin errors++; $display("FAIL b2b_stop1: got %0d expected 16", sl1); end
        checks++; if (gp2 != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle ticks expected 0", gp2); end
        checks++; if (b2[8:0] !== 9'h100) begin errors++; $display("FAIL b2b_bits2: got %h expected 100", b2[8:0]); end
        checks++; if (sl2 != 16) begin errors++; $display("FAIL b2b_stop2: got %0d expected 16", sl2); end
        checks++; if ((cl1 && cl2) !== 1'b1) begin errors++; $display("FAIL b2b_clean: got %b%b expected 11", cl1, cl2); end
        checks++; if (done_cnt - base != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - base); end
    endtask

    task automatic test_clamp_cfg_change();
        int base, qb, sl, gp, nx;
        logic [15:0] bits;
        bit cl;
        base = done_cnt; qb = samples.size();
        data_len = 4'd0; parity_mode = 2'b01; stop_sel = 2'b00;
        send(8'h80);
        repeat (100) @(negedge clk);
        parity_mode = 2'b10; data_len = 4'd3; stop_sel = 2'b10;
        wait_done(base, 1);
        decode(qb, 10, bits, sl, gp, cl, nx);
        checks++; if (bits[9:0] !== 10'h300) begin errors++; $display("FAIL clamp_bits: got %h expected 300", bits[9:0]); end
        checks++; if (cl !== 1'b1) begin errors++; $display("FAIL clamp_clean: got %b expected 1", cl); end
        checks++; if (sl != 16) begin errors++; $display("FAIL clamp_stop_len: got %0d expected 16", sl); end
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL clamp_done_count: got %0d expected 1", done_cnt - base); end
        data_len = 4'd8; parity_mode = 2'b00; stop_sel = 2'b00;
    endtask

    task automatic test_mid_reset();
        int base;
        bit saw_activity;
        base = done_cnt;
        data_len = 4'd8; parity_mode = 2'b00; stop_sel = 2'b00;
        send(8'h00);
        send(8'h55);
        repeat (210) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst_tx_before: got %b expected 0", tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_buffered: tx_ready %b expected 0", tx_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx_after: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_reset: got %b expected 0", tx_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_release: got %b expected 1", tx_ready); end
        saw_activity = 1'b0;
        repeat (700) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) saw_activity = 1'b1;
        end
        checks++; if (saw_activity !== 1'b0) begin errors++; $display("FAIL midrst_buffer_dropped: activity %b expected 0", saw_activity); end
        checks++; if (done_cnt - base != 0) begin errors++; $display("FAIL midrst_done_count: got %0d expected 0", done_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7x2(2'b01, 9'h186);
        test_7x2(2'b10, 9'h086);
        test_stop_1p5();
        test_back_to_back();
        test_clamp_cfg_change();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter, the successor to the fixed 8N1 transmitter. It supports variable data length, optional even/odd parity and 1/1.5/2 stop bits. A one-entry holding buffer with a valid/ready handshake allows back-to-back frames with no idle gap. It is driven by the shared baud-rate generator's oversample tick (s_tick), as the existing receiver/transmitter pair is.

Parameters:
DBIT_MAX, 8, width of tx_data and maximum data bits per frame (1..16)
OVS, 16, s_tick pulses per bit period; must be even and >= 4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
s_tick  in  1  oversample tick, one clk wide
tx_data  in  DBIT_MAX  word to send, LSB first
tx_valid  in  1  tx_data is valid
tx_ready  out  1  holding buffer empty; word accepted when tx_valid & tx_ready
data_len  in  4  data bits per frame, 1..DBIT_MAX
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
stop_sel  in  2  00 one, 01 one-and-half, 10/11 two stop bits
tx  out  1  serial line, idle high
busy  out  1  frame in progress (state != IDLE)
tx_done_tick  out  1  one-clk pulse at end of each frame

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. While reset==0 at a clk edge, after that edge: tx=1, tx_ready=0, busy=0, tx_done_tick=0, FSM in IDLE, holding buffer empty, all counters 0. On the first edge with reset==1, tx_ready goes to 1.
- Reset mid-frame aborts the frame; tx returns high at the next edge, and any buffered word is discarded.
- Holding buffer:
  - Accept when tx_valid & tx_ready at an edge; hold_valid is set and tx_ready drops after that edge.
  - The buffer is freed (tx_ready=1 after the edge) on the edge where the FSM loads it into the shift register.
  - tx_valid held while tx_ready=0 is stalled and has no effect.
- Frame config: data_len, parity_mode and stop_sel are sampled together with the data at the load edge. Changes during a frame affect only later frames.
- data_len clamp: data_len of 0 or greater than DBIT_MAX is treated as DBIT_MAX.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if hold_valid, load shift register and config, clear tick counter, go to START.
  - START: tx=0 for OVS ticks, then go to DATA with bit count 0.
  - DATA: tx = shift[0] for OVS ticks per bit, then shift right. After data_len bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx = parity bit for OVS ticks. Even mode: XOR of the data_len used bits. Odd mode: inverted XOR. Bits above data_len never affect parity.
  - STOP: tx=1 for OVS, OVS*3/2 or 2*OVS ticks according to stop_sel. On the final tick tx_done_tick=1 for exactly that cycle. If hold_valid is set, go directly to START (load happens on the same edge); else go to IDLE.
- Tick counter:
  - Width clog2(2*OVS); it only advances on s_tick. Between ticks all state holds.
  - An s_tick coincident with the load edge is not counted.
- tx is registered and is a function of the state and shift register. On tx_valid accepted at edge E from IDLE, the load happens at E+1 and tx=0 is driven from E+2.
- Back-to-back frames: the last stop tick is followed by the new start bit with zero extra bit periods.
- Simultaneous events: tx_valid accepted on the same edge the buffer is freed cannot occur (tx_ready=0 that cycle). A new word is accepted the following edge.

Test Plan:
- Frame 8N1: reset low 2 cycles, then tx_data=8'hA5, data_len=8, parity_mode=00, stop_sel=00 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; tx_done_tick once; busy low afterwards.
- 7E2 and odd parity: tx_data=8'hC3, data_len=7 -> bits 1,1,0,0,0,0,1, parity bit 1, stop high 32 ticks. Repeat with odd parity -> parity bit 0.
- 1.5 stop bits: stop_sel=01, OVS=16 -> stop phase exactly 24 ticks, measured from the last parity/data tick to tx_done_tick.
- Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> second word accepted during the first frame. The second start bit begins on the tick after the first frame's final stop tick; two tx_done_tick pulses; tx never idles between frames.
- Mid-frame reset: reset low during DATA bit 3 with one word buffered -> tx=1 after next edge, no tx_done_tick, buffer dropped, tx_ready=1 one edge after reset release.
- Clamp and config change: data_len=0 with DBIT_MAX=8 -> 8 data bits sent. Change parity_mode mid-frame -> current frame's parity is unchanged.
